// File: rtl/vec_mul_pkg.sv
// Shared types and constants for the byte-serial packed vector multiplier.
package vec_mul_pkg;

  localparam int LANE_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    SEW_8   = 2'b00,
    SEW_16  = 2'b01,
    SEW_32  = 2'b10,
    SEW_RSV = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIX,
    DONE
  } state_t;

  // Bytes per element, which is also the number of MUL cycles.
  function automatic logic [2:0] sew_bytes(input sew_e s);
    case (s)
      SEW_16:  return 3'd2;
      SEW_32:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/vec_mul_lane.sv
// One 32-bit lane: magnitude capture, byte-serial 8x32 accumulation per element,
// and a final conditional negation of each packed element result.
module vec_mul_lane
  import vec_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              step,
  input  logic              fix,
  input  sew_e              load_sew,
  input  sew_e              op_sew,
  input  logic              is_signed,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [1:0]        k,
  output logic [PROD_W-1:0] acc
);

  logic [LANE_W-1:0] mag_a, mag_b, mag_a_d, mag_b_d;
  logic [3:0]        neg, neg_d;
  logic [7:0]        b_byte [4];
  logic [31:0]       a_op   [4];
  logic [39:0]       pp     [4];
  logic [PROD_W-1:0] acc_step, acc_fix;

  // Magnitudes are kept as unsigned S-bit values so the most negative operand stays exact.
  always_comb begin
    mag_a_d = a;
    mag_b_d = b;
    neg_d   = '0;
    if (is_signed) begin
      case (load_sew)
        SEW_8: for (int j = 0; j < 4; j++) begin
          if (a[8*j+7]) mag_a_d[8*j +: 8] = -a[8*j +: 8];
          if (b[8*j+7]) mag_b_d[8*j +: 8] = -b[8*j +: 8];
          neg_d[j] = a[8*j+7] ^ b[8*j+7];
        end
        SEW_16: for (int j = 0; j < 2; j++) begin
          if (a[16*j+15]) mag_a_d[16*j +: 16] = -a[16*j +: 16];
          if (b[16*j+15]) mag_b_d[16*j +: 16] = -b[16*j +: 16];
          neg_d[j] = a[16*j+15] ^ b[16*j+15];
        end
        SEW_32: begin
          if (a[31]) mag_a_d = -a;
          if (b[31]) mag_b_d = -b;
          neg_d[0] = a[31] ^ b[31];
        end
        default: ;
      endcase
    end
  end

  // Slice j multiplies element j's full magnitude by byte k of its b magnitude.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      b_byte[j] = '0;
      a_op[j]   = '0;
    end
    case (op_sew)
      SEW_8: for (int j = 0; j < 4; j++) begin
        b_byte[j] = mag_b[8*j +: 8];
        a_op[j]   = {24'b0, mag_a[8*j +: 8]};
      end
      SEW_16: for (int j = 0; j < 2; j++) begin
        b_byte[j] = mag_b[16*j + 8*k +: 8];
        a_op[j]   = {16'b0, mag_a[16*j +: 16]};
      end
      SEW_32: begin
        b_byte[0] = mag_b[8*k +: 8];
        a_op[0]   = mag_a;
      end
      default: ;
    endcase
    for (int j = 0; j < 4; j++) pp[j] = 40'(b_byte[j]) * 40'(a_op[j]);
  end

  always_comb begin
    acc_step = acc;
    acc_fix  = acc;
    case (op_sew)
      SEW_8: for (int j = 0; j < 4; j++) begin
        acc_step[16*j +: 16] = acc[16*j +: 16] + pp[j][15:0];
        if (neg[j]) acc_fix[16*j +: 16] = -acc[16*j +: 16];
      end
      SEW_16: for (int j = 0; j < 2; j++) begin
        acc_step[32*j +: 32] = acc[32*j +: 32] + (pp[j][31:0] << (8*k));
        if (neg[j]) acc_fix[32*j +: 32] = -acc[32*j +: 32];
      end
      SEW_32: begin
        acc_step = acc + ({24'b0, pp[0]} << (8*k));
        if (neg[0]) acc_fix = -acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a <= '0;
      mag_b <= '0;
      neg   <= '0;
      acc   <= '0;
    end else if (clear) begin
      mag_a <= '0;
      mag_b <= '0;
      neg   <= '0;
      acc   <= '0;
    end else if (load) begin
      mag_a <= mag_a_d;
      mag_b <= mag_b_d;
      neg   <= neg_d;
      acc   <= '0;
    end else if (step) begin
      acc <= acc_step;
    end else if (fix) begin
      acc <= acc_fix;
    end
  end

endmodule

// File: rtl/vec_mul_seq.sv
// Multi-lane packed multiplier: handshake FSM (IDLE/MUL/FIX/DONE) driving NLANE
// byte-serial lanes; reserved element width completes immediately with err.
module vec_mul_seq
  import vec_mul_pkg::*;
#(
  parameter int NLANE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              sew,
  input  logic                    is_signed,
  input  logic [NLANE*LANE_W-1:0] a,
  input  logic [NLANE*LANE_W-1:0] b,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NLANE*PROD_W-1:0] prod,
  output logic                    err
);

  state_t     state, state_next;
  logic [1:0] k;
  sew_e       sew_q, sew_in;
  logic       err_q;
  logic       load, step, fix, clear, last_k;
  logic [2:0] nbytes;

  assign sew_in = sew_e'(sew);
  assign nbytes = sew_bytes(sew_q);
  assign last_k = ({1'b0, k} == nbytes - 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Flush overrides every other request, including a pending accept or output handshake.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    clear      = 1'b0;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    if (flush) begin
      clear      = 1'b1;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          load       = 1'b1;
          state_next = (sew_in == SEW_RSV) ? DONE : MUL;
        end
        MUL: begin
          step = 1'b1;
          if (last_k) state_next = FIX;
        end
        FIX: begin
          fix        = 1'b1;
          state_next = DONE;
        end
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      sew_q <= SEW_8;
      err_q <= 1'b0;
    end else if (clear) begin
      k     <= '0;
      err_q <= 1'b0;
    end else if (load) begin
      k     <= '0;
      sew_q <= sew_in;
      err_q <= (sew_in == SEW_RSV);
    end else if (step) begin
      k <= last_k ? 2'd0 : k + 2'd1;
    end else if (state == DONE && out_ready) begin
      err_q <= 1'b0;
    end
  end

  assign err = (state == DONE) && err_q;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    logic [PROD_W-1:0] acc;

    vec_mul_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .load      (load),
      .step      (step),
      .fix       (fix),
      .load_sew  (sew_in),
      .op_sew    (sew_q),
      .is_signed (is_signed),
      .a         (a[LANE_W*i +: LANE_W]),
      .b         (b[LANE_W*i +: LANE_W]),
      .k         (k),
      .acc       (acc)
    );

    assign prod[PROD_W*i +: PROD_W] = (state == DONE) ? acc : '0;
  end

endmodule

// File: tb/tb_vec_mul_seq.sv
// Directed self-checking bench for vec_mul_seq with NLANE=2 and hand-computed products.
module tb_vec_mul_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   sew;
  logic         is_signed;
  logic [63:0]  a, b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] prod;
  logic         err;

  int total = 0;
  int bad   = 0;

  vec_mul_seq #(.NLANE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sew       (sew),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Offers one bundle from IDLE, then counts edges (including the accept edge) until out_valid.
  task automatic run_op(input logic [1:0] s, input logic sg, input logic [63:0] av,
                        input logic [63:0] bv, output int lat);
    @(negedge clk);
    sew = s; is_signed = sg; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sew = 2'b00; is_signed = 1'b0;
    a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (prod !== 128'h0) begin bad++; $display("FAIL reset_prod got=%h want=0", prod); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_sew8_unsigned();
    int lat;
    run_op(2'b00, 1'b0, {32'h0102_0304, 32'hFF02_0310}, {32'h0506_0708, 32'hFF04_0510}, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sew8u_latency got=%0d want=3", lat); end
    total++; if (prod !== {64'h0005_000C_0015_0020, 64'hFE01_0008_000F_0100}) begin
      bad++; $display("FAIL sew8u_prod got=%h want=%h", prod, {64'h0005_000C_0015_0020, 64'hFE01_0008_000F_0100});
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sew8u_err got=%b want=0", err); end
    release_out();
    total++; if (out_valid !== 1'b0 || prod !== 128'h0) begin
      bad++; $display("FAIL sew8u_after_release out_valid=%b prod=%h want 0/0", out_valid, prod);
    end
  endtask

  task automatic test_sew8_signed();
    int lat;
    run_op(2'b00, 1'b1, {32'h0000_0001, 32'h807F_FE05}, {32'hFFFF_FFFF, 32'h8080_03FB}, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sew8s_latency got=%0d want=3", lat); end
    total++; if (prod !== {64'h0000_0000_0000_FFFF, 64'h4000_C080_FFFA_FFE7}) begin
      bad++; $display("FAIL sew8s_prod got=%h want=%h", prod, {64'h0000_0000_0000_FFFF, 64'h4000_C080_FFFA_FFE7});
    end
    release_out();
  endtask

  task automatic test_sew16_signed();
    int lat;
    run_op(2'b01, 1'b1, {32'h7FFF_8000, 32'h8000_FFFF}, {32'h8000_7FFF, 32'h8000_0002}, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL sew16s_latency got=%0d want=4", lat); end
    total++; if (prod !== {64'hC000_8000_C000_8000, 64'h4000_0000_FFFF_FFFE}) begin
      bad++; $display("FAIL sew16s_prod got=%h want=%h", prod, {64'hC000_8000_C000_8000, 64'h4000_0000_FFFF_FFFE});
    end
    release_out();
  endtask

  task automatic test_sew32();
    int lat;
    run_op(2'b10, 1'b0, {32'h8000_0000, 32'hFFFF_FFFF}, {32'h0000_0003, 32'hFFFF_FFFF}, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL sew32u_latency got=%0d want=6", lat); end
    total++; if (prod !== {64'h0000_0001_8000_0000, 64'hFFFF_FFFE_0000_0001}) begin
      bad++; $display("FAIL sew32u_prod got=%h want=%h", prod, {64'h0000_0001_8000_0000, 64'hFFFF_FFFE_0000_0001});
    end
    release_out();
    run_op(2'b10, 1'b1, {32'h8000_0000, 32'hFFFF_FFFF}, {32'h0000_0003, 32'hFFFF_FFFF}, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL sew32s_latency got=%0d want=6", lat); end
    total++; if (prod !== {64'hFFFF_FFFE_8000_0000, 64'h0000_0000_0000_0001}) begin
      bad++; $display("FAIL sew32s_prod got=%h want=%h", prod, {64'hFFFF_FFFE_8000_0000, 64'h0000_0000_0000_0001});
    end
    release_out();
  endtask

  // Output held under backpressure while a new bundle waits; it is taken only after the handshake.
  task automatic test_back_to_back();
    int lat;
    run_op(2'b01, 1'b0, {32'h0, 32'h0003_0100}, {32'h0, 32'h0005_0100}, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL b2b_first_latency got=%0d want=4", lat); end
    @(negedge clk);
    sew = 2'b00; is_signed = 1'b0; a = {32'h0, 32'h0000_0002}; b = {32'h0, 32'h0000_0003};
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || prod !== {64'h0, 64'h0000_000F_0001_0000}) begin
        bad++;
        $display("FAIL b2b_hold cycle=%0d out_valid=%b in_ready=%b prod=%h want 1/0/%h",
                 c, out_valid, in_ready, prod, {64'h0, 64'h0000_000F_0001_0000});
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_handshake_idle out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept in_ready=%b want=0", in_ready); end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== 3 || prod !== {64'h0, 64'h0000_0000_0000_0006}) begin
      bad++; $display("FAIL b2b_second_result lat=%0d prod=%h want 3/%h", lat, prod, {64'h0, 64'h6});
    end
    release_out();
  endtask

  task automatic test_flush_reset();
    int  lat;
    logic seen;
    @(negedge clk);
    sew = 2'b10; is_signed = 1'b0; a = '1; b = '1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (prod !== 128'h0) begin bad++; $display("FAIL mul_prod_zero got=%h want=0", prod); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_to_idle in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_output seen=%b want=0", seen); end
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod !== 128'h0) begin
      bad++; $display("FAIL midop_reset in_ready=%b out_valid=%b prod=%h want 1/0/0", in_ready, out_valid, prod);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_no_output seen=%b want=0", seen); end
    run_op(2'b11, 1'b0, {32'h1234_5678, 32'h9ABC_DEF0}, {32'h1111_1111, 32'h2222_2222}, lat);
    total++; if (lat !== 1 || err !== 1'b1 || prod !== 128'h0) begin
      bad++; $display("FAIL reserved_sew lat=%0d err=%b prod=%h want 1/1/0", lat, err, prod);
    end
    release_out();
    total++; if (err !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reserved_release err=%b out_valid=%b want 0/0", err, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sew8_unsigned();
    test_sew8_signed();
    test_sew16_signed();
    test_sew32();
    test_back_to_back();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_mul_seq.md
VEC_MUL_SEQ -- requirements
Module: vec_mul_seq

Interface
REQ-001 Parameter NLANE, default 2, number of 32-bit lanes; legal values 1..8.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand bundle valid.
REQ-005 in_ready  output  1  block can accept a bundle.
REQ-006 sew  input  2  element width: 00=8, 01=16, 10=32, 11=reserved.
REQ-007 is_signed  input  1  1=two's-complement operands, 0=unsigned.
REQ-008 a, b  input  NLANE*32 each  packed operands; element i of width S at [S*i +: S] within each lane.
REQ-009 flush  input  1  synchronous abort.
REQ-010 out_valid  output  1  product bundle valid.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 prod  output  NLANE*64  full 2S-bit product of element i at [2S*i +: 2S] within each 64-bit lane slice.
REQ-013 err  output  1  set with out_valid when the accepted sew was reserved.

Function
REQ-014 States IDLE, MUL, FIX, DONE; in_ready=1 only in IDLE.
REQ-015 IDLE: in_valid&in_ready latches a, b, sew, is_signed; go to MUL with byte counter k=0 and accumulators cleared; sew=11 goes directly to DONE with prod=0, err=1.
REQ-016 On latch, signed mode stores per-element magnitudes |a|, |b| and per-element negate flag = sign(a) XOR sign(b); unsigned mode stores operands unchanged, flags 0.
REQ-017 MUL: each cycle every element accumulates mag_a * mag_b byte k, shifted left 8*k, into a 2S-bit accumulator; k increments.
REQ-018 MUL lasts S/8 cycles (1, 2, 4), then FIX.
REQ-019 FIX: one cycle; elements with negate flag set have their accumulator replaced by its two's complement modulo 2^(2S); then DONE.
REQ-020 DONE: out_valid=1, prod and err stable; on out_ready go to IDLE.
REQ-021 Latency accept-to-out_valid = S/8+2 cycles (3, 4, 6); out_valid held until out_ready without change.
REQ-022 No new accept while DONE; a bundle offered during DONE&out_ready is accepted no earlier than the following cycle.
REQ-023 Most negative signed operand (0x80, 0x8000, 0x80000000) yields the exact product; the magnitude is held as unsigned S bits.
REQ-024 flush in any state: next state IDLE, out_valid=0, err=0, accumulators cleared; flush wins over in_valid and out_ready in the same cycle.
REQ-025 Byte counter width 2 bits; never wraps within an operation.
REQ-026 prod is 0 in every state other than DONE.

Reset
REQ-027 rst asserted: state=IDLE, k=0, accumulators/operands/flags=0, out_valid=0, err=0, prod=0, in_ready=1 after deassertion.
REQ-028 rst mid-operation discards the operation; no out_valid is produced for it.

Structure
REQ-029 Package vec_mul_pkg holds sew_e enum, state_t enum, LANE_W=32, PROD_W=64, and function sew_bytes(sew_e) returning 1/2/4.
REQ-030 Sub-module vec_mul_lane: one 32-bit lane with 4 byte-slice 8x32 partial product paths, packed-element accumulation and FIX negation; vec_mul_seq instantiates NLANE copies and owns the FSM and handshake.
REQ-031 No multiplier wider than 8x32 per lane per cycle.

Verification
REQ-032 sew=00 unsigned, lane0 a=0xFF02_0310, b=0xFF04_0510 -> after 3 cycles prod lane0 = 0xFE01_0008_000F_0100.
REQ-033 sew=01 signed, a=0x8000_FFFF, b=0x8000_0002 -> after 4 cycles lane0 = 0x4000_0000_FFFF_FFFE.
REQ-034 sew=10 unsigned, a=0xFFFF_FFFF, b=0xFFFF_FFFF -> after 6 cycles lane0 = 0xFFFF_FFFE_0000_0001; signed same operands -> 0x0000_0000_0000_0001.
REQ-035 out_ready low 5 cycles in DONE -> out_valid and prod held; in_valid high throughout is accepted only on the cycle after the out handshake.
REQ-036 flush in MUL cycle 2 of a sew=10 op, then rst pulse mid next op -> no out_valid for either; next op sew=11 -> out_valid after 1 cycle with err=1, prod=0.
